// File: rtl/load_store_unit_pkg.sv
// Shared sizes, fault codes, FSM states and the registered bus command
// used by the load/store unit and its lane-alignment helper.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_SIZE     = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

    // Only the five RISC-V load/store funct3 encodings are accepted
    function automatic logic size_legal(input logic [2:0] size);
        return (size == SZ_B) || (size == SZ_H) || (size == SZ_W) ||
               (size == SZ_BU) || (size == SZ_HU);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request, memory-bus and result signals of the load/store unit.
// slave is the unit's view; master is the execute stage plus memory side.
interface load_store_unit_if;
    import lsu_pkg::*;

    logic            req_valid;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [2:0]      req_size;
    logic            req_ready;
    logic            busy;

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [BE_W-1:0] mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    logic            done;
    logic [XLEN-1:0] ld_data;
    logic [2:0]      ld_size;
    logic            fault_valid;
    logic [1:0]      fault_code;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size,
        input  mem_ready, mem_rdata,
        output req_ready, busy,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output done, ld_data, ld_size, fault_valid, fault_code
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size,
        output mem_ready, mem_rdata,
        input  req_ready, busy,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  done, ld_data, ld_size, fault_valid, fault_code
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: byte enables, replicated store data and
// alignment / size legality for one request.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]      size,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    output logic [BE_W-1:0] be_c,
    output logic [XLEN-1:0] wdata_c,
    output logic            misaligned_c,
    output logic            illegal_size_c
);

    // size[1:0] picks the access width; size[2] only selects zero-extension downstream
    always_comb begin
        be_c           = '0;
        wdata_c        = wdata;
        misaligned_c   = 1'b0;
        illegal_size_c = !size_legal(size);
        case (size[1:0])
            2'b00: begin
                be_c    = BE_W'(4'b0001 << addr_lo);
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_c         = BE_W'(4'b0011 << addr_lo);
                wdata_c      = {2{wdata[15:0]}};
                misaligned_c = addr_lo[0];
            end
            2'b10: begin
                be_c         = BE_W'(4'b1111);
                misaligned_c = |addr_lo;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: accepts one load/store, drives a single-outstanding
// word bus, returns shifted load data or reports faults and bus timeouts.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  bus
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    mem_cmd_t        cmd_q, cmd_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic [2:0]      size_q, size_d;
    logic            mem_req_q, mem_req_d;
    logic            req_ready_q, req_ready_d;
    logic            done_q, done_d;
    logic            fault_valid_q, fault_valid_d;
    logic [1:0]      fault_code_q, fault_code_d;
    logic [XLEN-1:0] ld_data_q, ld_data_d;
    logic [2:0]      ld_size_q, ld_size_d;

    logic [BE_W-1:0] be_c;
    logic [XLEN-1:0] wdata_c;
    logic            misaligned_c;
    logic            illegal_size_c;

    lsu_lane_align u_lane_align (
        .size           (bus.req_size),
        .addr_lo        (bus.req_addr[1:0]),
        .wdata          (bus.req_wdata),
        .be_c           (be_c),
        .wdata_c        (wdata_c),
        .misaligned_c   (misaligned_c),
        .illegal_size_c (illegal_size_c)
    );

    // Next-state, counter and result logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd_q;
        addr_lo_d     = addr_lo_q;
        size_d        = size_q;
        done_d        = 1'b0;
        fault_valid_d = 1'b0;
        fault_code_d  = fault_code_q;
        ld_data_d     = ld_data_q;
        ld_size_d     = ld_size_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (illegal_size_c) begin
                        fault_valid_d = 1'b1;
                        fault_code_d  = FLT_SIZE;
                    end else if (misaligned_c) begin
                        fault_valid_d = 1'b1;
                        fault_code_d  = FLT_MISALIGN;
                    end else begin
                        cmd_d.we    = bus.req_we;
                        cmd_d.addr  = {bus.req_addr[XLEN-1:2], 2'b00};
                        cmd_d.be    = be_c;
                        cmd_d.wdata = wdata_c;
                        addr_lo_d   = bus.req_addr[1:0];
                        size_d      = bus.req_size;
                        cnt_d       = '0;
                        state_d     = BUSY;
                    end
                end
            end
            BUSY: begin
                // A completing transfer takes precedence over an expiring timeout
                if (bus.mem_ready) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    if (!cmd_q.we) begin
                        ld_data_d = bus.mem_rdata >> {addr_lo_q, 3'b000};
                        ld_size_d = size_q;
                    end
                end else if (TO_EN && (cnt_q == CNT_LAST)) begin
                    fault_valid_d = 1'b1;
                    fault_code_d  = FLT_TIMEOUT;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        mem_req_d   = (state_d == BUSY);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            cmd_q         <= '0;
            addr_lo_q     <= '0;
            size_q        <= '0;
            mem_req_q     <= 1'b0;
            req_ready_q   <= 1'b1;
            done_q        <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_code_q  <= '0;
            ld_data_q     <= '0;
            ld_size_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_q         <= cmd_d;
            addr_lo_q     <= addr_lo_d;
            size_q        <= size_d;
            mem_req_q     <= mem_req_d;
            req_ready_q   <= req_ready_d;
            done_q        <= done_d;
            fault_valid_q <= fault_valid_d;
            fault_code_q  <= fault_code_d;
            ld_data_q     <= ld_data_d;
            ld_size_q     <= ld_size_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.busy        = mem_req_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = cmd_q.we;
    assign bus.mem_addr    = cmd_q.addr;
    assign bus.mem_be      = cmd_q.be;
    assign bus.mem_wdata   = cmd_q.wdata;
    assign bus.done        = done_q;
    assign bus.ld_data     = ld_data_q;
    assign bus.ld_size     = ld_size_q;
    assign bus.fault_valid = fault_valid_q;
    assign bus.fault_code  = fault_code_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage that sits directly upstream of the load-data sign/zero-extension stage in the NeuroRISC core. It accepts one load or store per request from the execute stage, checks alignment and size, and drives a word-aligned single-outstanding memory bus with byte enables and lane-replicated store data. It returns load data shifted down to bit 0, with upper bits zero-filled and unextended, together with the registered RISC-V funct3 size for the extension stage. It also provides a pipeline-stall signal and fault reporting, including a bus timeout.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles `mem_req` stays high without `mem_ready`; 0 disables the timeout.
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents a memory op.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- req_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_ready  out  1  unit idle; a request is accepted on `req_valid & req_ready`.
- busy  out  1  transaction in flight; stalls the pipeline.
- mem_req  out  1  bus request, held until `mem_ready` or timeout.
- mem_we  out  1  bus write.
- mem_addr  out  32  `{req_addr[31:2], 2'b00}`.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  bus completes the transfer this cycle; `mem_rdata` is valid when the op is a load.
- mem_rdata  in  32  read word.
- done  out  1  one-cycle completion pulse for loads and stores.
- ld_data  out  32  `mem_rdata >> (8*addr[1:0])`, zero-filled; valid with `done` on loads.
- ld_size  out  3  registered `req_size` of the completed op.
- fault_valid  out  1  one-cycle fault pulse.
- fault_code  out  2  01 misaligned, 10 illegal size, 11 bus timeout.

## Operation
- States:
  - IDLE: `req_ready=1`.
  - BUSY: `mem_req=1`, `busy=1`.
- On acceptance, check in priority order:
  - Illegal size (011, 110, 111): fault 10, stay IDLE.
  - Misaligned: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0. Fault 01, stay IDLE.
  - Otherwise: register addr, we, size, be, wdata; go to BUSY.
- A faulted request never asserts `mem_req`.
- Byte enables:
  - B/BU: `4'b0001 << addr[1:0]`.
  - H/HU: `4'b0011 << addr[1:0]`.
  - W: `4'b1111`.
- Store data: B → `{4{wdata[7:0]}}`; H → `{2{wdata[15:0]}}`; W → `wdata`.
- For loads, `mem_be` reflects the accessed bytes; the memory may ignore it.
- BUSY with `mem_ready`=1: capture the shifted `ld_data` on loads; pulse `done` next cycle; go to IDLE.
- Timeout counter:
  - Clears on entry to BUSY and increments each BUSY cycle without `mem_ready`.
  - If `TIMEOUT_CYCLES`≠0 and the counter equals `TIMEOUT_CYCLES-1` with no `mem_ready`: go to IDLE and pulse fault 11 next cycle.
  - `mem_ready` in the same cycle wins over the timeout.
- Counter width: `$clog2(TIMEOUT_CYCLES+1)`.
- `ld_data` and `ld_size` hold their values until the next load completes.

## Timing
- Reset values: `req_ready` 1 after deassertion; all other outputs 0 (state IDLE, counter 0).
- Reset asserted mid-BUSY:
  - `mem_req` drops asynchronously.
  - No `done` or fault is issued.
  - The in-flight op is discarded.
- Request accepted at edge 0:
  - `mem_req`, `mem_addr`, `mem_be`, `mem_wdata` are valid from cycle 1.
  - `mem_ready` sampled high at edge k → `done` high in cycle k+1. Minimum latency is 2 cycles (k=1).
  - `req_ready` is high in the same cycle as `done`, so the next op can be accepted there.
  - Peak throughput: one op per 2 cycles.
- Fault pulse: high in cycle 1 after the accepting edge.
- Timeout: `mem_req` is high for exactly `TIMEOUT_CYCLES` cycles, then the fault pulse follows.
- `done` and `fault_valid` are never high together.
- Bus outputs are registered, and stable for the whole BUSY period.

## Structure
- `lsu_pkg`:
  - funct3 size localparams: SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU.
  - Fault codes: FLT_MISALIGN, FLT_SIZE, FLT_TIMEOUT.
  - State enum: IDLE, BUSY.
- One combinational sub-module, `lsu_lane_align`: from size, `addr[1:0]` and wdata it produces be, replicated wdata, misaligned and illegal_size.
- The FSM, counter, registers and load shift live in `load_store_unit`.

## Test plan
- Store B, addr 0x1003, wdata 0x000000AB, `mem_ready` in cycle 1 → `mem_addr` 0x1000, `mem_be` 1000, `mem_wdata` 0xABABABAB, `mem_we` 1, `done` in cycle 2.
- Load HU, addr 0x2002, `mem_rdata` 0xBEEF1234, `mem_ready` in cycle 3 → `mem_be` 1100, `ld_data` 0x0000BEEF, `ld_size` 101, `done` in cycle 4; new load accepted in cycle 4.
- Load W, addr 0x3001 → no `mem_req`, fault_code 01 pulse in cycle 1, `req_ready` stays 1.
- `req_size` 011 at addr 0x4000 → fault_code 10, no bus activity.
- TIMEOUT_CYCLES=4, `mem_ready` held 0 → `mem_req` high for cycles 1–4, fault_code 11 in cycle 5, `req_ready` 1; repeat with `mem_ready` in cycle 4 → `done` in cycle 5, no fault.
- `rst` pulsed in cycle 2 of a BUSY load → `mem_req` 0 immediately, no `done`/fault, all outputs 0; op accepted normally after release.
